// File: rtl/eq_pkg.sv
// Shared constants, FSM encoding and output conversion for the band mixer.
// Optional feature macro: EQ_MIX_SAT_EN (used by eq_band_mac_sched).
package eq_pkg;

  localparam int EQ_N_BANDS   = 10;
  localparam int EQ_DW        = 24;
  localparam int EQ_GAIN_FRAC = 23;
  localparam int EQ_ACC_W     = 2*EQ_DW + 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } eq_state_t;

  typedef struct packed {
    logic             sat;
    logic [EQ_DW-1:0] val;
  } eq_out_t;

  // Clamp an already-shifted accumulator value to DW bits. The shift floors
  // (arithmetic), so no rounding increment is applied here.
  function automatic eq_out_t eq_sat_round(input logic signed [EQ_ACC_W-1:0] s);
    eq_out_t                  r;
    logic [EQ_ACC_W-EQ_DW:0]  hi;
    hi = s[EQ_ACC_W-1:EQ_DW-1];
    if ((&hi) || (~|hi)) begin
      r.sat = 1'b0;
      r.val = s[EQ_DW-1:0];
    end else if (!s[EQ_ACC_W-1]) begin
      r.sat = 1'b1;
      r.val = {1'b0, {(EQ_DW-1){1'b1}}};
    end else begin
      r.sat = 1'b1;
      r.val = {1'b1, {(EQ_DW-1){1'b0}}};
    end
    return r;
  endfunction

endpackage

// File: rtl/eq_mac_unit.sv
// Shared signed multiplier with registered accumulator.
// clr loads zero, en adds sext(a*b); acc_nxt exposes the value that will be
// registered so the scheduler can capture the final sum on the last MAC cycle.
module eq_mac_unit #(
  parameter int DW    = 24,
  parameter int ACC_W = 2*DW + 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_clr,
  input  logic                    i_en,
  input  logic signed [DW-1:0]    i_a,
  input  logic signed [DW-1:0]    i_b,
  output logic signed [ACC_W-1:0] o_acc,
  output logic signed [ACC_W-1:0] o_acc_nxt
);

  logic signed [2*DW-1:0]  w_prod;
  logic signed [ACC_W-1:0] w_prod_ext;
  logic signed [ACC_W-1:0] r_acc;

  assign w_prod     = i_a * i_b;
  assign w_prod_ext = {{(ACC_W-2*DW){w_prod[2*DW-1]}}, w_prod};

  // Next accumulator value: clear has priority over accumulate.
  always_comb begin
    o_acc_nxt = r_acc;
    if (i_clr) begin
      o_acc_nxt = '0;
    end else if (i_en) begin
      o_acc_nxt = r_acc + w_prod_ext;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else begin
      r_acc <= o_acc_nxt;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/eq_band_mac_sched.sv
// Time-multiplexed 10-band mixer: one shared MAC walks the snapshotted bands,
// then scales, optionally clamps, and presents one output per accepted sample.
// Optional feature macro: EQ_MIX_SAT_EN (clamp instead of wrap on overflow).
//
// state | meaning
// IDLE  | waiting for sample_valid, ready high
// MAC   | one band product accumulated per cycle, ready low
// OUT   | out_valid high for this cycle, ready high (back-to-back accept)
module eq_band_mac_sched
  import eq_pkg::*;
#(
  parameter int N_BANDS   = EQ_N_BANDS,
  parameter int DW        = EQ_DW,
  parameter int OUT_SHIFT = EQ_GAIN_FRAC,
  parameter int ACC_W     = 2*DW + 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sample_valid,
  output logic                  sample_ready,
  input  logic [N_BANDS*DW-1:0] band_data,
  input  logic [N_BANDS*DW-1:0] gains,
  output logic [DW-1:0]         audio_out,
  output logic                  out_valid,
  output logic                  overrun,
  output logic                  sat_flag
);

  localparam int IDX_W = $clog2(N_BANDS);

  eq_state_t r_state;
  eq_state_t w_state_nxt;

  logic                  w_ready;
  logic                  w_accept;
  logic                  w_mac_clr;
  logic                  w_mac_en;
  logic                  w_last;

  logic [N_BANDS*DW-1:0] r_band;
  logic [N_BANDS*DW-1:0] r_gain;
  logic [IDX_W-1:0]      r_idx;
  logic [DW-1:0]         r_audio;
  logic                  r_out_valid;
  logic                  r_sat;
  logic                  r_overrun;

  logic signed [DW-1:0]    w_a;
  logic signed [DW-1:0]    w_b;
  logic signed [ACC_W-1:0] w_acc;
  logic signed [ACC_W-1:0] w_acc_nxt;
  logic signed [ACC_W-1:0] w_scaled;
  logic [DW-1:0]           w_res_val;
  logic                    w_res_sat;

  assign w_a = r_band[r_idx*DW +: DW];
  assign w_b = r_gain[r_idx*DW +: DW];

  eq_mac_unit #(
    .DW    (DW),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (w_mac_clr),
    .i_en      (w_mac_en),
    .i_a       (w_a),
    .i_b       (w_b),
    .o_acc     (w_acc),
    .o_acc_nxt (w_acc_nxt)
  );

  // Scale the final sum (including the last product) so the result can be
  // registered on the same edge that enters OUT.
  assign w_scaled = w_acc_nxt >>> OUT_SHIFT;

`ifdef EQ_MIX_SAT_EN
  assign {w_res_sat, w_res_val} = eq_sat_round(w_scaled);
`else
  assign w_res_val = w_scaled[DW-1:0];
  assign w_res_sat = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and control decode.
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_accept    = 1'b0;
    w_mac_clr   = 1'b0;
    w_mac_en    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      ST_IDLE, ST_OUT: begin
        w_ready = 1'b1;
        if (sample_valid) begin
          w_accept    = 1'b1;
          w_mac_clr   = 1'b1;
          w_state_nxt = ST_MAC;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_MAC: begin
        w_mac_en = 1'b1;
        if (r_idx == IDX_W'(N_BANDS-1)) begin
          w_last      = 1'b1;
          w_state_nxt = ST_OUT;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Snapshot, band index, result registers and sticky overrun.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_band      <= '0;
      r_gain      <= '0;
      r_idx       <= '0;
      r_audio     <= '0;
      r_out_valid <= 1'b0;
      r_sat       <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (w_accept) begin
        r_band <= band_data;
        r_gain <= gains;
        r_idx  <= '0;
      end else if (w_last) begin
        r_idx <= '0;
      end else if (w_mac_en) begin
        r_idx <= r_idx + 1'b1;
      end
      if (w_last) begin
        r_audio     <= w_res_val;
        r_sat       <= w_res_sat;
        r_out_valid <= 1'b1;
      end
      if (sample_valid && !w_ready) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign sample_ready = w_ready;
  assign audio_out    = r_audio;
  assign out_valid    = r_out_valid;
  assign sat_flag     = r_sat;
  assign overrun      = r_overrun;

endmodule
